mcp_tx: RTL and testbench

MCP_TX -- requirements
Module: mcp_tx

---
 rtl/mcp_pkg.sv | 15 +
 rtl/mcp_sync.sv | 27 ++
 rtl/mcp_tx.sv | 115 +++++++++++
 tb/tb_mcp_tx.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mcp_pkg.sv
// Shared definitions for the multicycle-path (MCP) toggle handshake pair.
// Holds the FSM state type and default widths so mcp_tx and a future mcp_rx
// agree on encoding and bus sizing.
package mcp_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LAUNCH   = 2'd1,
    WAIT_ACK = 2'd2
  } mcp_state_t;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/mcp_sync.sv
// Multi-flop level synchronizer for a single asynchronous bit.
// Latency: STAGES rising edges from d_i change to q_o change.
// Backpressure: none; free-running shift chain.
// Ports: clk/reset (async active-high, clears all stages), d_i async input,
//        q_o synchronized output (last stage).
module mcp_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/mcp_tx.sv
// Source side of a toggle req/ack multicycle-path transfer.
// Latency: accept at edge T, mcp_data valid after T, mcp_req toggles at T+1.
// Backpressure: in_ready only in IDLE; one word in flight until ack or timeout.
// Ports: clk, reset (async active-high); in_valid/in_data/in_ready upstream;
//        mcp_data/mcp_req out, mcp_ack in (async) to destination;
//        busy, xfer_count (mod 8), err (sticky) status.
module mcp_tx
  import mcp_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int TIMEOUT     = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [WIDTH-1:0] mcp_data,
  output logic             mcp_req,
  input  logic             mcp_ack,
  output logic             busy,
  output logic [2:0]       xfer_count,
  output logic             err
);

  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  mcp_state_t       state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             req_q, req_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             err_q, err_d;
  logic [7:0]       timer_q, timer_d;
  logic             ack_prev_q;
  logic             ack_sync;

  mcp_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (mcp_ack),
    .q_o   (ack_sync)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    req_d   = req_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    timer_d = timer_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        // Data has been stable for one cycle; now announce it.
        req_d   = ~req_q;
        timer_d = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        // Completion wins over a timeout landing on the same edge.
        if (ack_sync == req_q) begin
          cnt_d   = cnt_q + 3'd1;
          state_d = IDLE;
        end else if (timer_q == TIMER_LAST) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // An ack edge outside WAIT_ACK is only legal if it restores
    // ack_sync == mcp_req (a late ack after a timeout).
    if (state_q != WAIT_ACK && ack_sync != ack_prev_q && ack_sync != req_q) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      data_q     <= '0;
      req_q      <= 1'b0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      timer_q    <= '0;
      ack_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      req_q      <= req_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      timer_q    <= timer_d;
      ack_prev_q <= ack_sync;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign mcp_data   = data_q;
  assign mcp_req    = req_q;
  assign xfer_count = cnt_q;
  assign err        = err_q;

endmodule

// File: tb/tb_mcp_tx.sv
module tb_mcp_tx;

  localparam int W  = 8;
  localparam int SS = 2;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic [W-1:0] mcp_data;
  logic         mcp_req;
  logic         mcp_ack;
  logic         busy;
  logic [2:0]   xfer_count;
  logic         err;

  int total = 0;
  int bad   = 0;

  // Reference model: expected req level, completed count, sticky error.
  logic exp_req;
  int   exp_cnt;
  logic exp_err;

  always #5 clk = ~clk;

  mcp_tx #(.WIDTH(W), .SYNC_STAGES(SS), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .mcp_data   (mcp_data),
    .mcp_req    (mcp_req),
    .mcp_ack    (mcp_ack),
    .busy       (busy),
    .xfer_count (xfer_count),
    .err        (err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_status();
    chk("xfer_count", {29'd0, xfer_count}, exp_cnt[31:0]);
    chk("err", {31'd0, err}, {31'd0, exp_err});
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    chk("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset    = 1'b1;
    mcp_ack  = 1'b0;
    in_valid = 1'b0;
    #30;
    reset    = 1'b0;
    exp_req  = 1'b0;
    exp_cnt  = 0;
    exp_err  = 1'b0;
  endtask

  // Accept a word and check it is on the bus before req moves, and req
  // moves exactly one edge after the accept.
  task automatic launch(input logic [W-1:0] d);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = W'($urandom);
    chk("accept_data", {24'd0, mcp_data}, {24'd0, d});
    chk("req_before_toggle", {31'd0, mcp_req}, {31'd0, exp_req});
    chk("in_ready_low", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    exp_req = ~exp_req;
    chk("req_toggle", {31'd0, mcp_req}, {31'd0, exp_req});
    chk("data_stable_req", {24'd0, mcp_data}, {24'd0, d});
  endtask

  // Wait for return to IDLE, checking req/data hold while pending.
  task automatic wait_idle(input logic [W-1:0] d, output int n);
    n = 0;
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
      if (!in_ready) begin
        chk("req_hold_pending", {31'd0, mcp_req}, {31'd0, exp_req});
        chk("data_hold_pending", {24'd0, mcp_data}, {24'd0, d});
      end
    end
    if (!in_ready) chk("idle_timeout_bound", 32'd0, 32'd1);
  endtask

  task automatic do_xfer(input logic [W-1:0] d, input int dly);
    int n;
    launch(d);
    repeat (dly) begin
      @(negedge clk);
      chk("req_hold_dly", {31'd0, mcp_req}, {31'd0, exp_req});
    end
    mcp_ack = ~mcp_ack;
    wait_idle(d, n);
    chk("ack_to_idle_cycles", n, SS + 1);
    exp_cnt = (exp_cnt + 1) % 8;
    chk("data_after_done", {24'd0, mcp_data}, {24'd0, d});
    chk_status();
  endtask

  initial begin
    int n;
    logic [W-1:0] seq [5];
    logic [W-1:0] w;
    seq[0] = 8'd10; seq[1] = 8'd10; seq[2] = 8'd20; seq[3] = 8'd60; seq[4] = 8'd240;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; mcp_ack = 1'b0;
    exp_req = 1'b0; exp_cnt = 0; exp_err = 1'b0;
    #1;
    chk("rst_async_ready", {31'd0, in_ready}, 32'd1);
    apply_reset();
    chk("rst_data", {24'd0, mcp_data}, 32'd0);
    chk("rst_req", {31'd0, mcp_req}, 32'd0);
    chk_status();

    // Single transfer, ack 3 cycles after req.
    do_xfer(8'h0A, 3);

    // Ordered sequence with randomized ack delay.
    for (int i = 0; i < 5; i++) do_xfer(seq[i], $urandom_range(0, 3));

    // Wrap: 9 transfers from a clean reset.
    apply_reset();
    for (int i = 0; i < 9; i++) do_xfer(W'($urandom), $urandom_range(0, 3));
    chk("wrap_count", {29'd0, xfer_count}, 32'd1);

    // Timeout: no ack.
    w = W'($urandom);
    launch(w);
    wait_idle(w, n);
    chk("timeout_cycles", n, TO);
    exp_err = 1'b1;
    chk_status();
    // Late ack restores consistency; state untouched.
    mcp_ack = ~mcp_ack;
    repeat (SS + 3) @(negedge clk);
    chk_status();
    // Transfers still work afterwards.
    do_xfer(W'($urandom), 1);

    // Unsolicited ack toggle while IDLE.
    apply_reset();
    chk_status();
    mcp_ack = ~mcp_ack;
    repeat (SS + 3) @(negedge clk);
    exp_err = 1'b1;
    chk_status();
    chk("unsolicited_req", {31'd0, mcp_req}, 32'd0);

    // Reset asserted mid-WAIT_ACK takes effect asynchronously.
    apply_reset();
    launch(8'h5C);
    @(negedge clk);
    #2;
    reset = 1'b1;
    mcp_ack = 1'b0;
    #1;
    exp_req = 1'b0; exp_cnt = 0; exp_err = 1'b0;
    chk("async_rst_data", {24'd0, mcp_data}, 32'd0);
    chk("async_rst_req", {31'd0, mcp_req}, 32'd0);
    chk_status();
    #27;
    reset = 1'b0;
    do_xfer(W'($urandom), $urandom_range(0, 3));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: got expired expected finished");
    $fatal(1);
  end

endmodule
